// File: rtl/avalon_pio_pulse_if.sv
// Avalon-MM slave bus bundle for the PIO/pulse block.
// The master drives address and write qualifiers, the slave returns readdata.
interface avalon_pio_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/avalon_pio_pulse.sv
// Avalon-MM general-purpose I/O: output register with set/clear aliases,
// self-timed pulse generator, and a synchronised input port with
// rising-edge capture and a maskable level interrupt.
//
// Pulse FSM states:
//   state  | meaning
//   IDLE   | no pulse in flight, pulse_bits = 0
//   ACTIVE | pulse_bits driven onto out_port, count runs down to 0
module avalon_pio_pulse #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PULSE_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_pio_pulse_if.slave     bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN - 1);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_IN      = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;
    localparam logic [2:0] A_PULSE   = 3'd6;
    localparam logic [2:0] A_STATUS  = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] pulse_bits;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] rise;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wd;
    logic                  pulse_trig;
    logic                  busy;
    logic [31:0]           count_ext;
    logic [31:0]           status;
    logic                  unused_wd_hi;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wd           = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wd_hi = ^bus.writedata;
    assign pulse_trig   = wr_en && (bus.address == A_PULSE) && (wd != '0);
    assign busy         = (state == ACTIVE);
    assign rise         = sync2 & ~prev;

    assign count_ext    = 32'(count);
    assign status       = {count_ext[15:0], 15'd0, busy};

    assign out_port     = out_reg | pulse_bits;
    assign irq          = |(edgecap & irqmask);

    // Pulse generator: a write (new or retrigger) reloads the down-counter;
    // terminal count drops the pulse bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            pulse_bits <= '0;
        end else if (pulse_trig) begin
            state      <= ACTIVE;
            count      <= CNT_LOAD;
            pulse_bits <= pulse_bits | wd;
        end else if (state == ACTIVE) begin
            if (count == '0) begin
                state      <= IDLE;
                pulse_bits <= '0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    // Software-visible registers: output register with its set/clear
    // aliases, interrupt mask, and edge capture where a new edge beats W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg <= RESET_OUT;
            irqmask <= '0;
            edgecap <= '0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    A_DATA:    out_reg <= wd;
                    A_OUTSET:  out_reg <= out_reg | wd;
                    A_OUTCLR:  out_reg <= out_reg & ~wd;
                    A_IRQMASK: irqmask <= wd;
                    default:   ;
                endcase
            end
            if (wr_en && (bus.address == A_EDGECAP))
                edgecap <= (edgecap & ~wd) | rise;
            else
                edgecap <= edgecap | rise;
        end
    end

    // Two-flop synchroniser plus a delay stage for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero.
    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                A_DATA:    bus.readdata = 32'(out_reg);
                A_IN:      bus.readdata = 32'(sync2);
                A_IRQMASK: bus.readdata = 32'(irqmask);
                A_EDGECAP: bus.readdata = 32'(edgecap);
                A_OUTSET:  bus.readdata = '0;
                A_OUTCLR:  bus.readdata = '0;
                A_PULSE:   bus.readdata = 32'(pulse_bits);
                A_STATUS:  bus.readdata = status;
                default:   bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_pio_pulse.sv
// Directed and randomised checks of avalon_pio_pulse against a behavioural
// model built from the register-map rules.
module tb_avalon_pio_pulse;
    localparam int DW = 8;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_port = '0;
    logic [DW-1:0] out_port;
    logic          irq;

    avalon_pio_pulse_if bus();

    avalon_pio_pulse #(
        .DATA_WIDTH(DW),
        .PULSE_LEN (PL),
        .RESET_OUT (8'h00)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .in_port (in_port),
        .out_port(out_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_out   = '0;
    logic [DW-1:0] m_mask  = '0;
    logic [DW-1:0] m_cap   = '0;
    logic [DW-1:0] m_pbits = '0;
    int            m_rem   = 0;      // cycles the pulse still has to stay high
    logic [DW-1:0] hist[$];          // in_port samples, newest first

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        r = '0;
        if (bus.chipselect) begin
            case (bus.address)
                3'd0: r = 32'(m_out);
                3'd1: r = 32'(hist[1]);
                3'd2: r = 32'(m_mask);
                3'd3: r = 32'(m_cap);
                3'd6: r = 32'(m_pbits);
                3'd7: r = (m_rem > 0) ? ((32'(m_rem - 1) << 16) | 32'd1) : 32'd0;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [DW-1:0] wd;
        logic          wr;
        logic [DW-1:0] edges;
        wd = bus.writedata[DW-1:0];
        wr = bus.chipselect && !bus.write_n;
        if (reset) begin
            m_out = '0; m_mask = '0; m_cap = '0; m_pbits = '0; m_rem = 0;
            hist = '{8'h00, 8'h00, 8'h00};
            return;
        end
        edges = hist[1] & ~hist[2];
        if (wr && bus.address == 3'd6 && wd != '0) begin
            m_pbits = m_pbits | wd;
            m_rem   = PL;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_pbits = '0;
        end
        m_cap = (m_cap & ~((wr && bus.address == 3'd3) ? wd : 8'h00)) | edges;
        if (wr) begin
            case (bus.address)
                3'd0: m_out = wd;
                3'd2: m_mask = wd;
                3'd4: m_out = m_out | wd;
                3'd5: m_out = m_out & ~wd;
                default: ;
            endcase
        end
        hist.push_front(in_port);
        void'(hist.pop_back());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out_port", 32'(out_port), 32'(m_out | m_pbits));
        chk("irq", 32'(irq), 32'(|(m_cap & m_mask)));
        chk("readdata", bus.readdata, exp_rd());
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        cycle();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(logic [2:0] a, logic [31:0] exp, string tag);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        chk(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    initial begin
        hist = '{8'h00, 8'h00, 8'h00};
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state and DATA write
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, "reset_read");
        chk("reset_out", 32'(out_port), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        wr(3'd0, 32'h1A5);
        chk("data_out", 32'(out_port), 32'hA5);
        rd(3'd0, 32'hA5, "data_rd");

        // Set / clear aliases
        wr(3'd0, 32'hF0);
        wr(3'd4, 32'h0F);
        chk("outset", 32'(out_port), 32'hFF);
        wr(3'd5, 32'h81);
        chk("outclr", 32'(out_port), 32'h7E);
        rd(3'd4, 32'h0, "outset_rd");
        rd(3'd5, 32'h0, "outclr_rd");

        // Single pulse: 4 cycles high, count 3..0
        wr(3'd0, 32'h0);
        wr(3'd6, 32'h01);
        for (int i = 0; i < PL; i++) begin
            chk("pulse_bit0", 32'(out_port[0]), 32'h1);
            rd(3'd7, (32'(PL - 1 - i) << 16) | 32'h1, "pulse_status");
            cycle();
        end
        chk("pulse_end", 32'(out_port), 32'h0);
        rd(3'd7, 32'h0, "pulse_idle");

        // Retrigger two cycles later extends both bits
        wr(3'd6, 32'h01);
        cycle();
        wr(3'd6, 32'h02);
        for (int i = 0; i < PL; i++) begin
            chk("retrig", 32'(out_port), 32'h03);
            cycle();
        end
        chk("retrig_end", 32'(out_port), 32'h0);
        wr(3'd6, 32'h00);
        chk("pulse_zero", 32'(out_port), 32'h0);
        rd(3'd7, 32'h0, "pulse_zero_st");

        // Input synchroniser, edge capture, interrupt
        wr(3'd2, 32'h04);
        in_port = 8'h04;
        cycle();
        cycle();
        rd(3'd1, 32'h04, "in_sync");
        rd(3'd3, 32'h00, "cap_pre");
        chk("irq_pre", 32'(irq), 32'h0);
        cycle();
        rd(3'd3, 32'h04, "cap_set");
        chk("irq_set", 32'(irq), 32'h1);
        repeat (3) cycle();
        wr(3'd3, 32'h04);
        rd(3'd3, 32'h00, "cap_w1c");
        chk("irq_clr", 32'(irq), 32'h0);
        in_port = 8'h00;
        repeat (4) cycle();
        in_port = 8'h04;
        cycle();
        cycle();
        wr(3'd3, 32'h04);
        rd(3'd3, 32'h04, "cap_set_wins");
        chk("irq_set_wins", 32'(irq), 32'h1);

        // Reset mid-pulse, with a bus write in the same cycle
        wr(3'd0, 32'h55);
        wr(3'd6, 32'h0A);
        cycle();
        reset = 1'b1;
        bus.address = 3'd0; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'hFF;
        cycle();
        reset = 1'b0;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(3'd7, 32'h0, "rst_busy");
        rd(3'd3, 32'h0, "rst_cap");

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) in_port = DW'($urandom);
            reset = ($urandom_range(0, 59) == 0);
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = ($urandom_range(0, 1) == 0);
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            cycle();
        end
        reset = 1'b0;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
